// File: rtl/uart_command_pkg.sv
// Command codes and frame-parser state encoding shared by the UART RX decoder and TX-side controller.
package uart_command_pkg;

    localparam int unsigned CMD_WIDTH = 8;

    localparam logic [CMD_WIDTH-1:0] CMD_WRITE        = 8'hAA;
    localparam logic [CMD_WIDTH-1:0] CMD_READ         = 8'hBB;
    localparam logic [CMD_WIDTH-1:0] CMD_ALU_OPERANDS = 8'hCC;
    localparam logic [CMD_WIDTH-1:0] CMD_ALU_ONLY     = 8'hDD;
    localparam logic [CMD_WIDTH-1:0] CMD_BURST_WRITE  = 8'hEE;

    typedef enum logic [3:0] {
        IDLE        = 4'd0,
        WR_ADDR     = 4'd1,
        WR_DATA     = 4'd2,
        RD_ADDR     = 4'd3,
        OP_A        = 4'd4,
        OP_B        = 4'd5,
        ALU_FUNC    = 4'd6,
        BURST_ADDR  = 4'd7,
        BURST_COUNT = 4'd8,
        BURST_DATA  = 4'd9
    } frame_state_e;

endpackage

// File: rtl/frame_timeout_counter.sv
// Inter-byte watchdog: counts enabled cycles since the last clear, flags when the limit is reached.
module frame_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_enable,
    output logic expired
);

    localparam int unsigned COUNT_WIDTH = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [COUNT_WIDTH-1:0] LIMIT = COUNT_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [COUNT_WIDTH-1:0] count;

    // Saturates at the limit so a frozen or lingering expiry never wraps back to zero.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (count_enable && !expired) begin
            count <= count + COUNT_WIDTH'(1);
        end
    end

    assign expired = (count == LIMIT);

endmodule

// File: rtl/uart_command_frame_decoder.sv
// Parses UART RX command frames into register-file write/read strobes and ALU start strobes.
module uart_command_frame_decoder
    import uart_command_pkg::*;
#(
    parameter int unsigned DATA_WIDTH          = 8,
    parameter int unsigned REGISTER_FILE_DEPTH = 16,
    parameter int unsigned ALU_FUNCTION_WIDTH  = 4,
    parameter int unsigned OPERAND_A_ADDRESS   = 0,
    parameter int unsigned OPERAND_B_ADDRESS   = 1,
    parameter int unsigned TIMEOUT_CYCLES      = 4096
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          enable,
    input  logic                                          parallel_data_valid_synchronized,
    input  logic [DATA_WIDTH-1:0]                         parallel_data_synchronized,
    output logic [ALU_FUNCTION_WIDTH-1:0]                 ALU_function,
    output logic                                          ALU_enable,
    output logic                                          ALU_clk_enable,
    output logic [((REGISTER_FILE_DEPTH > 1) ? $clog2(REGISTER_FILE_DEPTH) : 1)-1:0] address,
    output logic                                          write_enable,
    output logic [DATA_WIDTH-1:0]                         write_data,
    output logic                                          read_enable,
    output logic                                          busy,
    output logic                                          frame_error
);

    localparam int unsigned ADDR_WIDTH = (REGISTER_FILE_DEPTH > 1) ? $clog2(REGISTER_FILE_DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(REGISTER_FILE_DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] OPA_ADDR  = ADDR_WIDTH'(OPERAND_A_ADDRESS);
    localparam logic [ADDR_WIDTH-1:0] OPB_ADDR  = ADDR_WIDTH'(OPERAND_B_ADDRESS);

    frame_state_e state, state_next;

    logic                          valid_prev;
    logic                          accept;
    logic                          addr_in_range;
    logic [ADDR_WIDTH-1:0]         rx_addr;
    logic [ADDR_WIDTH-1:0]         ptr, ptr_next;
    logic [DATA_WIDTH-1:0]         remaining, remaining_next;
    logic [ADDR_WIDTH-1:0]         address_next;
    logic [DATA_WIDTH-1:0]         write_data_next;
    logic [ALU_FUNCTION_WIDTH-1:0] alu_function_next;
    logic                          write_enable_next;
    logic                          read_enable_next;
    logic                          alu_enable_next;
    logic                          frame_error_next;
    logic                          timer_expired;
    logic                          timeout_hit;

    // A held valid level counts once: only its rising edge accepts a byte.
    assign accept        = enable && parallel_data_valid_synchronized && !valid_prev;
    assign addr_in_range = 32'(parallel_data_synchronized) < REGISTER_FILE_DEPTH;
    assign rx_addr       = ADDR_WIDTH'(parallel_data_synchronized);
    assign timeout_hit   = timer_expired && enable && (state != IDLE);

    frame_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk          (clk),
        .reset        (reset),
        .clear        (accept || (state == IDLE)),
        .count_enable (enable && (state != IDLE)),
        .expired      (timer_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            valid_prev     <= 1'b0;
            ptr            <= '0;
            remaining      <= '0;
            address        <= '0;
            write_data     <= '0;
            ALU_function   <= '0;
            write_enable   <= 1'b0;
            read_enable    <= 1'b0;
            ALU_enable     <= 1'b0;
            ALU_clk_enable <= 1'b0;
            frame_error    <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state          <= state_next;
            valid_prev     <= parallel_data_valid_synchronized;
            ptr            <= ptr_next;
            remaining      <= remaining_next;
            address        <= address_next;
            write_data     <= write_data_next;
            ALU_function   <= alu_function_next;
            write_enable   <= write_enable_next;
            read_enable    <= read_enable_next;
            ALU_enable     <= alu_enable_next;
            ALU_clk_enable <= alu_enable_next || ALU_enable;
            frame_error    <= frame_error_next;
            busy           <= (state_next != IDLE);
        end
    end

    // Next state and next register values; an accepted byte takes priority over timeout expiry.
    always_comb begin
        state_next        = state;
        ptr_next          = ptr;
        remaining_next    = remaining;
        address_next      = address;
        write_data_next   = write_data;
        alu_function_next = ALU_function;
        write_enable_next = 1'b0;
        read_enable_next  = 1'b0;
        alu_enable_next   = 1'b0;
        frame_error_next  = 1'b0;

        if (accept) begin
            unique case (state)
                IDLE: begin
                    if (parallel_data_synchronized == DATA_WIDTH'(CMD_WRITE)) begin
                        state_next = WR_ADDR;
                    end else if (parallel_data_synchronized == DATA_WIDTH'(CMD_READ)) begin
                        state_next = RD_ADDR;
                    end else if (parallel_data_synchronized == DATA_WIDTH'(CMD_ALU_OPERANDS)) begin
                        state_next = OP_A;
                    end else if (parallel_data_synchronized == DATA_WIDTH'(CMD_ALU_ONLY)) begin
                        state_next = ALU_FUNC;
                    end else if (parallel_data_synchronized == DATA_WIDTH'(CMD_BURST_WRITE)) begin
                        state_next = BURST_ADDR;
                    end else begin
                        frame_error_next = 1'b1;
                    end
                end
                WR_ADDR, BURST_ADDR: begin
                    if (addr_in_range) begin
                        ptr_next   = rx_addr;
                        state_next = (state == WR_ADDR) ? WR_DATA : BURST_COUNT;
                    end else begin
                        frame_error_next = 1'b1;
                        state_next       = IDLE;
                    end
                end
                WR_DATA: begin
                    write_enable_next = 1'b1;
                    address_next      = ptr;
                    write_data_next   = parallel_data_synchronized;
                    state_next        = IDLE;
                end
                RD_ADDR: begin
                    if (addr_in_range) begin
                        read_enable_next = 1'b1;
                        address_next     = rx_addr;
                    end else begin
                        frame_error_next = 1'b1;
                    end
                    state_next = IDLE;
                end
                OP_A, OP_B: begin
                    write_enable_next = 1'b1;
                    address_next      = (state == OP_A) ? OPA_ADDR : OPB_ADDR;
                    write_data_next   = parallel_data_synchronized;
                    state_next        = (state == OP_A) ? OP_B : ALU_FUNC;
                end
                ALU_FUNC: begin
                    alu_enable_next   = 1'b1;
                    alu_function_next = ALU_FUNCTION_WIDTH'(parallel_data_synchronized);
                    state_next        = IDLE;
                end
                BURST_COUNT: begin
                    if (parallel_data_synchronized == '0) begin
                        frame_error_next = 1'b1;
                        state_next       = IDLE;
                    end else begin
                        remaining_next = parallel_data_synchronized;
                        state_next     = BURST_DATA;
                    end
                end
                BURST_DATA: begin
                    write_enable_next = 1'b1;
                    address_next      = ptr;
                    write_data_next   = parallel_data_synchronized;
                    ptr_next          = (ptr == LAST_ADDR) ? '0 : ptr + ADDR_WIDTH'(1);
                    remaining_next    = remaining - DATA_WIDTH'(1);
                    if (remaining == DATA_WIDTH'(1)) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end else if (timeout_hit) begin
            frame_error_next = 1'b1;
            state_next       = IDLE;
        end
    end

endmodule

// File: tb/tb_uart_command_frame_decoder.sv
// Directed self-checking bench for uart_command_frame_decoder with default parameters.
module tb_uart_command_frame_decoder;

    localparam int unsigned TIMEOUT = 4096;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b1;
    logic       valid = 1'b0;
    logic [7:0] data = 8'h00;
    logic [3:0] alu_function;
    logic       alu_enable;
    logic       alu_clk_enable;
    logic [3:0] address;
    logic       write_enable;
    logic [7:0] write_data;
    logic       read_enable;
    logic       busy;
    logic       frame_error;

    int errors = 0;
    int checks = 0;

    logic [3:0] wr_addr_q[$];
    logic [7:0] wr_data_q[$];
    int         rd_count = 0;
    logic [3:0] rd_addr_last = 4'h0;
    int         alu_en_count = 0;
    int         alu_clk_count = 0;
    int         ferr_count = 0;

    always #5 clk = ~clk;

    uart_command_frame_decoder dut (
        .clk                              (clk),
        .reset                            (reset),
        .enable                           (enable),
        .parallel_data_valid_synchronized (valid),
        .parallel_data_synchronized       (data),
        .ALU_function                     (alu_function),
        .ALU_enable                       (alu_enable),
        .ALU_clk_enable                   (alu_clk_enable),
        .address                          (address),
        .write_enable                     (write_enable),
        .write_data                       (write_data),
        .read_enable                      (read_enable),
        .busy                             (busy),
        .frame_error                      (frame_error)
    );

    // Strobe log, sampled away from the active edge.
    always @(negedge clk) begin
        if (write_enable) begin
            wr_addr_q.push_back(address);
            wr_data_q.push_back(write_data);
        end
        if (read_enable) begin
            rd_count     = rd_count + 1;
            rd_addr_last = address;
        end
        if (alu_enable)     alu_en_count  = alu_en_count + 1;
        if (alu_clk_enable) alu_clk_count = alu_clk_count + 1;
        if (frame_error)    ferr_count    = ferr_count + 1;
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        valid = 1'b1;
        data  = b;
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({alu_function, alu_enable, alu_clk_enable, address, write_enable, write_data,
             read_enable, busy, frame_error} !== 23'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", {alu_function, alu_enable, alu_clk_enable,
                     address, write_enable, write_data, read_enable, busy, frame_error});
        end
        reset = 1'b0;
        settle();
    endtask

    task automatic test_write();
        send_byte(8'hAA);
        send_byte(8'h0D);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL write_busy_mid: got %b expected 1", busy); end
        @(negedge clk);
        valid = 1'b1;
        data  = 8'hCF;
        @(negedge clk);
        valid = 1'b0;
        checks++;
        if ({write_enable, address, write_data} !== {1'b1, 4'hD, 8'hCF}) begin
            errors++;
            $display("FAIL write_strobe: got we=%b a=%h d=%h expected we=1 a=d d=cf", write_enable, address, write_data);
        end
        @(negedge clk);
        checks++;
        if (write_enable !== 1'b0) begin errors++; $display("FAIL write_pulse_width: got %b expected 0", write_enable); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL write_busy_end: got %b expected 0", busy); end
        settle();
    endtask

    task automatic test_read_held();
        int rd0 = rd_count;
        int wr0 = wr_addr_q.size();
        send_byte(8'hBB);
        @(negedge clk);
        valid = 1'b1;
        data  = 8'h08;
        repeat (5) @(negedge clk);
        valid = 1'b0;
        settle();
        checks++;
        if (rd_count - rd0 !== 1) begin errors++; $display("FAIL read_pulses: got %0d expected 1", rd_count - rd0); end
        checks++;
        if (rd_addr_last !== 4'h8) begin errors++; $display("FAIL read_address: got %h expected 8", rd_addr_last); end
        checks++;
        if (wr_addr_q.size() - wr0 !== 0) begin errors++; $display("FAIL read_no_write: got %0d expected 0", wr_addr_q.size() - wr0); end
    endtask

    task automatic test_alu_operands();
        int wr0  = wr_addr_q.size();
        int en0  = alu_en_count;
        int clk0 = alu_clk_count;
        send_byte(8'hCC);
        send_byte(8'h09);
        send_byte(8'h0A);
        send_byte(8'h04);
        settle();
        checks++;
        if (wr_addr_q.size() - wr0 !== 2) begin errors++; $display("FAIL alu_write_count: got %0d expected 2", wr_addr_q.size() - wr0); end
        checks++;
        if ({wr_addr_q[wr0], wr_data_q[wr0], wr_addr_q[wr0+1], wr_data_q[wr0+1]} !== {4'h0, 8'h09, 4'h1, 8'h0A}) begin
            errors++;
            $display("FAIL alu_operands: got %h@%h %h@%h expected 09@0 0a@1",
                     wr_data_q[wr0], wr_addr_q[wr0], wr_data_q[wr0+1], wr_addr_q[wr0+1]);
        end
        checks++;
        if (alu_function !== 4'h4) begin errors++; $display("FAIL alu_function: got %h expected 4", alu_function); end
        checks++;
        if (alu_en_count - en0 !== 1) begin errors++; $display("FAIL alu_enable_cycles: got %0d expected 1", alu_en_count - en0); end
        checks++;
        if (alu_clk_count - clk0 !== 2) begin errors++; $display("FAIL alu_clk_cycles: got %0d expected 2", alu_clk_count - clk0); end
    endtask

    task automatic test_burst();
        logic [3:0] exp_a [3] = '{4'hE, 4'hF, 4'h0};
        logic [7:0] exp_d [3] = '{8'h11, 8'h22, 8'h33};
        int wr0 = wr_addr_q.size();
        int fe0 = ferr_count;
        send_byte(8'hEE);
        send_byte(8'h0E);
        send_byte(8'h03);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        settle();
        checks++;
        if (wr_addr_q.size() - wr0 !== 3) begin errors++; $display("FAIL burst_count: got %0d expected 3", wr_addr_q.size() - wr0); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({wr_addr_q[wr0+i], wr_data_q[wr0+i]} !== {exp_a[i], exp_d[i]}) begin
                errors++;
                $display("FAIL burst_beat%0d: got %h@%h expected %h@%h", i, wr_data_q[wr0+i], wr_addr_q[wr0+i], exp_d[i], exp_a[i]);
            end
        end
        checks++;
        if (ferr_count - fe0 !== 0) begin errors++; $display("FAIL burst_no_error: got %0d expected 0", ferr_count - fe0); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL burst_busy_end: got %b expected 0", busy); end
    endtask

    task automatic test_errors();
        int wr0 = wr_addr_q.size();
        int rd0 = rd_count;
        int fe0 = ferr_count;
        send_byte(8'hAA);
        send_byte(8'h14);
        settle();
        checks++;
        if (ferr_count - fe0 !== 1) begin errors++; $display("FAIL bad_write_addr_error: got %0d expected 1", ferr_count - fe0); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL bad_write_addr_busy: got %b expected 0", busy); end
        send_byte(8'h7F);
        settle();
        checks++;
        if (ferr_count - fe0 !== 2) begin errors++; $display("FAIL illegal_cmd_error: got %0d expected 2", ferr_count - fe0); end
        send_byte(8'hEE);
        send_byte(8'h05);
        send_byte(8'h00);
        settle();
        checks++;
        if (ferr_count - fe0 !== 3) begin errors++; $display("FAIL burst_zero_error: got %0d expected 3", ferr_count - fe0); end
        send_byte(8'hBB);
        send_byte(8'h10);
        settle();
        checks++;
        if (ferr_count - fe0 !== 4) begin errors++; $display("FAIL bad_read_addr_error: got %0d expected 4", ferr_count - fe0); end
        checks++;
        if ({wr_addr_q.size() - wr0, rd_count - rd0} !== {32'd0, 32'd0}) begin
            errors++;
            $display("FAIL error_no_strobes: got wr=%0d rd=%0d expected 0 0", wr_addr_q.size() - wr0, rd_count - rd0);
        end
    endtask

    task automatic test_timeout();
        int en0 = alu_en_count;
        int seen = 0;
        send_byte(8'hAA);
        // The accept edge precedes this negedge; expiry is seen TIMEOUT negedges later.
        for (int k = 2; k <= TIMEOUT + 20; k++) begin
            @(negedge clk);
            if (frame_error === 1'b1) begin
                seen = k;
                break;
            end
        end
        checks++;
        if (seen !== TIMEOUT + 1) begin errors++; $display("FAIL timeout_latency: got %0d expected %0d", seen, TIMEOUT + 1); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy: got %b expected 0", busy); end
        send_byte(8'hDD);
        send_byte(8'h0E);
        settle();
        checks++;
        if (alu_function !== 4'hE) begin errors++; $display("FAIL alu_only_function: got %h expected e", alu_function); end
        checks++;
        if (alu_en_count - en0 !== 1) begin errors++; $display("FAIL alu_only_enable: got %0d expected 1", alu_en_count - en0); end
    endtask

    task automatic test_enable_hold();
        int wr0 = wr_addr_q.size();
        int fe0 = ferr_count;
        send_byte(8'hAA);
        enable = 1'b0;
        send_byte(8'h07);
        repeat (TIMEOUT + 50) @(negedge clk);
        checks++;
        if ({busy, 32'(ferr_count - fe0)} !== {1'b1, 32'd0}) begin
            errors++;
            $display("FAIL enable_freeze: got busy=%b errors=%0d expected busy=1 errors=0", busy, ferr_count - fe0);
        end
        enable = 1'b1;
        send_byte(8'h03);
        send_byte(8'h5A);
        settle();
        checks++;
        if (wr_addr_q.size() - wr0 !== 1) begin errors++; $display("FAIL enable_resume_count: got %0d expected 1", wr_addr_q.size() - wr0); end
        checks++;
        if ({wr_addr_q[wr0], wr_data_q[wr0]} !== {4'h3, 8'h5A}) begin
            errors++;
            $display("FAIL enable_resume_write: got %h@%h expected 5a@3", wr_data_q[wr0], wr_addr_q[wr0]);
        end
    endtask

    task automatic test_reset_mid_frame();
        int wr0 = wr_addr_q.size();
        int rd0 = rd_count;
        send_byte(8'hAA);
        send_byte(8'h05);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_mid_busy: got %b expected 0", busy); end
        send_byte(8'hBB);
        send_byte(8'h02);
        settle();
        checks++;
        if ({wr_addr_q.size() - wr0, rd_count - rd0, 28'(0), rd_addr_last} !== {32'd0, 32'd1, 28'd0, 4'h2}) begin
            errors++;
            $display("FAIL reset_mid_discard: got wr=%0d rd=%0d a=%h expected wr=0 rd=1 a=2",
                     wr_addr_q.size() - wr0, rd_count - rd0, rd_addr_last);
        end
    endtask

    task automatic test_back_to_back();
        int wr0 = wr_addr_q.size();
        int rd0 = rd_count;
        send_byte(8'hAA);
        send_byte(8'h01);
        send_byte(8'h11);
        send_byte(8'hBB);
        send_byte(8'h0F);
        settle();
        checks++;
        if ({wr_addr_q[wr0], wr_data_q[wr0]} !== {4'h1, 8'h11}) begin
            errors++;
            $display("FAIL b2b_write: got %h@%h expected 11@1", wr_data_q[wr0], wr_addr_q[wr0]);
        end
        checks++;
        if ({rd_count - rd0, 28'(0), rd_addr_last} !== {32'd1, 28'd0, 4'hF}) begin
            errors++;
            $display("FAIL b2b_read: got rd=%0d a=%h expected rd=1 a=f", rd_count - rd0, rd_addr_last);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_held();
        test_alu_operands();
        test_burst();
        test_errors();
        test_timeout();
        test_enable_hold();
        test_reset_mid_frame();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
